pkt_delay_line: RTL and testbench
=================================

// Module: pkt_delay_line
// PURPOSE
//  Datapath stage of the delay module. It sits in the user data path and consumes the
//  delay_reset pulse driven by the delay register block. Every word is held in an
//  internal FIFO, tagged with its arrival time. A word is released once it has been
//  buffered for delay_cycles clocks, so packets are delayed uniformly and stay in order.
// PARAMETERS
//  DATA_WIDTH       64              datapath word width
//  CTRL_WIDTH       DATA_WIDTH/8    ctrl bus width
//  FIFO_DEPTH_BITS  9               log2 of FIFO depth in words (DEPTH = 2**FIFO_DEPTH_BITS)
//  TS_WIDTH         32              free-running timestamp width
// PORTS
//  clk           in   1           clock; all logic on posedge clk
//  reset         in   1           reset, synchronous, active-high
//  in_data       in   DATA_WIDTH  upstream word
//  in_ctrl       in   CTRL_WIDTH  upstream ctrl (8'hFF = module header / start of packet)
//  in_wr         in   1           upstream write strobe
//  in_rdy        out  1           this block can accept a word next cycle
//  out_data      out  DATA_WIDTH  downstream word (registered)
//  out_ctrl      out  CTRL_WIDTH  downstream ctrl (registered)
//  out_wr        out  1           downstream write strobe (registered)
//  out_rdy       in   1           downstream can accept
//  delay_cycles  in   TS_WIDTH    required hold time in clocks; must be < 2**(TS_WIDTH-1)
//  delay_reset   in   1           one-cycle flush pulse from the delay register block
// BEHAVIOUR
//  - Reset: FIFO empty; now=0; out_wr=0; out_data=0; out_ctrl=0; in_rdy=1 from the first cycle after reset.
//  - now: TS_WIDTH counter, +1 every cycle, wraps freely. Not cleared by delay_reset.
//  - Write: in_wr=1 in cycle t stores {in_ctrl,in_data,ts=now(t)}.
//  - in_rdy = (count < DEPTH-1). One slot is reserved to absorb the single late write after in_rdy drops.
//  - in_wr while count==DEPTH: word dropped, count unchanged; this is a protocol violation.
//  - FIFO is show-ahead. A stored word becomes head-visible in cycle t+1 at the earliest.
//  - Release decision in cycle c: head valid AND out_rdy AND (now - head.ts) >= delay_cycles.
//    The subtraction is modulo 2**TS_WIDTH, so wrap of now is harmless.
//  - When a release is decided: pop the head; out_wr, out_data and out_ctrl are registered and visible in cycle c+1.
//  - When no release is decided: out_wr=0 next cycle; out_data/out_ctrl hold their last value.
//  - Latency in_wr -> out_wr is max(delay_cycles+1, 2) clocks when out_rdy is held high.
//  - out_rdy low stalls release, with no loss. Released words stay back-to-back; at most one pop per cycle.
//  - Simultaneous push and pop: count unchanged. Empty and full counts are both exact.
//  - delay_cycles may change at any time and applies to the head immediately. Lowering it may
//    release a burst at one word/cycle. Order is never violated.
//  - delay_reset=1 in cycle t, evaluated after reset:
//    * count:=0; no pop in t; out_wr=0 in t+1.
//    * An in_wr in cycle t is dropped.
//    * A partially transmitted packet is truncated; the downstream tolerates this.
//  - reset has priority over delay_reset.
// CONFIGURATION
//  DELAY_STATS_EN defined:
//   - Adds output ports pkt_count[31:0] and flush_drop_words[31:0].
//   - pkt_count: +1 per released word with out_ctrl==8'hFF.
//   - flush_drop_words: += count at each delay_reset, plus 1 if in_wr was dropped in the same cycle.
//   - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset only.
//  DELAY_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. delay_cycles=10, out_rdy=1, single word in_wr at cycle 100 -> out_wr=1 only at cycle 111, data/ctrl equal.
//  2. delay_cycles=0, 3-word packet (ctrl FF,00,10) at cycles 50-52 -> out_wr at 52,53,54, same order and values.
//  3. delay_cycles=1000, write DEPTH-1 words -> in_rdy=0 after 511th word; one extra write accepted, next dropped.
//     Same test after 1000 cycles -> all 512 words out in order.
//  4. 20 words buffered, delay_reset pulse, in_wr same cycle -> count 0, no out_wr afterwards.
//     With DELAY_STATS_EN: flush_drop_words=21.
//  5. delay_cycles=5, out_rdy=0 for 30 cycles covering 4 queued words -> nothing out.
//     out_rdy=1 -> 4 consecutive out_wr starting 1 cycle later.
//  6. Force now to 32'hFFFF_FFF8, delay_cycles=16, write word -> released 17 cycles later across the wrap.

Source files
------------

// File: rtl/pkt_delay_line.sv
// -----------------------------------------------------------------------------
// pkt_delay_line
//
// Purpose:
//   Datapath stage of the delay module. Every incoming word is stored in an
//   internal show-ahead FIFO together with the value of a free-running
//   timestamp counter at arrival. The head word is released once it has been
//   buffered for at least delay_cycles clocks, so all words see the same delay
//   and leave in arrival order. A one-cycle delay_reset pulse empties the FIFO.
//
// Ports:
//   clk              in   clock, all logic on posedge
//   reset            in   synchronous, active-high; has priority over delay_reset
//   in_data/in_ctrl  in   upstream word and ctrl (ctrl all-ones = module header)
//   in_wr            in   upstream write strobe
//   in_rdy           out  word can be accepted next cycle (count < DEPTH-1)
//   out_data/ctrl    out  downstream word and ctrl (registered, hold when idle)
//   out_wr           out  downstream write strobe (registered)
//   out_rdy          in   downstream can accept a word
//   delay_cycles     in   hold time in clocks, must stay below 2**(TS_WIDTH-1)
//   delay_reset      in   one-cycle flush pulse
//   pkt_count        out  (DELAY_STATS_EN only) released header words, saturating
//   flush_drop_words out  (DELAY_STATS_EN only) words discarded by flushes, saturating
//
// Handshake:
//   Upstream: a word is taken in every cycle in_wr=1. in_rdy is a credit-style
//   indication for the *next* cycle; one FIFO slot is kept spare so that the
//   single write issued in the cycle in_rdy drops is still absorbed. A write
//   arriving when all DEPTH slots are occupied is discarded.
//   Downstream: a word is transferred in the cycle after the release decision
//   (out_wr=1); out_rdy must be high in the decision cycle.
//
// Configuration:
//   Define DELAY_STATS_EN to add the pkt_count / flush_drop_words counters.
// -----------------------------------------------------------------------------
module pkt_delay_line #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
   parameter int FIFO_DEPTH_BITS = 9,
   parameter int TS_WIDTH        = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  in_wr,
   output logic                  in_rdy,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic                  out_wr,
   input  logic                  out_rdy,
   input  logic [TS_WIDTH-1:0]   delay_cycles,
   input  logic                  delay_reset
`ifdef DELAY_STATS_EN
   ,
   output logic [31:0]           pkt_count,
   output logic [31:0]           flush_drop_words
`endif
);

   localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
   localparam int ENTRY_W = CTRL_WIDTH + DATA_WIDTH + TS_WIDTH;
   localparam int CNT_W   = FIFO_DEPTH_BITS + 1;

   localparam logic [CNT_W-1:0]           LP_DEPTH    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]           LP_DEPTH_M1 = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]           LP_CNT_ONE  = CNT_W'(1);
   localparam logic [FIFO_DEPTH_BITS-1:0] LP_PTR_ONE  = FIFO_DEPTH_BITS'(1);
   localparam logic [TS_WIDTH-1:0]        LP_TS_ONE   = TS_WIDTH'(1);

   // FIFO storage: entry = {ctrl, data, arrival timestamp}
   logic [ENTRY_W-1:0]         r_mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
   logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
   logic [CNT_W-1:0]           r_count;
   logic [TS_WIDTH-1:0]        r_now;

   logic                  r_out_wr;
   logic [DATA_WIDTH-1:0] r_out_data;
   logic [CTRL_WIDTH-1:0] r_out_ctrl;

   logic [ENTRY_W-1:0]    w_head;
   logic [TS_WIDTH-1:0]   w_head_ts;
   logic [DATA_WIDTH-1:0] w_head_data;
   logic [CTRL_WIDTH-1:0] w_head_ctrl;
   logic [TS_WIDTH-1:0]   w_age;
   logic                  w_head_valid;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;

   // Show-ahead read: the head entry is always presented combinationally.
   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_ts   = w_head[TS_WIDTH-1:0];
   assign w_head_data = w_head[TS_WIDTH +: DATA_WIDTH];
   assign w_head_ctrl = w_head[TS_WIDTH + DATA_WIDTH +: CTRL_WIDTH];

   // Modular subtraction: correct across a wrap of r_now as long as the
   // real age stays below 2**TS_WIDTH.
   assign w_age        = r_now - w_head_ts;
   assign w_head_valid = (r_count != '0);
   assign w_full       = (r_count == LP_DEPTH);

   assign w_pop  = w_head_valid && out_rdy && (w_age >= delay_cycles) && !delay_reset;
   assign w_push = in_wr && !w_full && !delay_reset;

   assign in_rdy   = (r_count < LP_DEPTH_M1);
   assign out_wr   = r_out_wr;
   assign out_data = r_out_data;
   assign out_ctrl = r_out_ctrl;

   // Storage array carries no reset; validity is tracked by r_count only.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {in_ctrl, in_data, r_now};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_now    <= '0;
      end else begin
         // The timestamp keeps running through a flush.
         r_now <= r_now + LP_TS_ONE;
         if (delay_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + LP_CNT_ONE;
               2'b01:   r_count <= r_count - LP_CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Output register: strobe follows the pop decision, data holds when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_wr   <= 1'b0;
         r_out_data <= '0;
         r_out_ctrl <= '0;
      end else begin
         r_out_wr <= w_pop;
         if (w_pop) begin
            r_out_data <= w_head_data;
            r_out_ctrl <= w_head_ctrl;
         end
      end
   end

`ifdef DELAY_STATS_EN
   logic [31:0] r_pkt_count;
   logic [31:0] r_flush_drop;
   logic [32:0] w_flush_sum;

   // Words lost in a flush: everything buffered plus a write in the same cycle.
   assign w_flush_sum = {1'b0, r_flush_drop} + 33'(r_count) + 33'(in_wr);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pkt_count  <= '0;
         r_flush_drop <= '0;
      end else begin
         if (w_pop && (w_head_ctrl == '1) && (r_pkt_count != 32'hFFFF_FFFF)) begin
            r_pkt_count <= r_pkt_count + 32'd1;
         end
         if (delay_reset) begin
            r_flush_drop <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
         end
      end
   end

   assign pkt_count        = r_pkt_count;
   assign flush_drop_words = r_flush_drop;
`endif

endmodule

// File: tb/tb_pkt_delay_line.sv
// -----------------------------------------------------------------------------
// tb_pkt_delay_line
//
// Bench for pkt_delay_line. Main instance uses default parameters; a second
// instance with an 8-bit timestamp exercises timestamp wrap in a few hundred
// cycles. A queue-based reference model tracks the main instance every cycle.
// -----------------------------------------------------------------------------
module tb_pkt_delay_line;

   localparam int DW    = 64;
   localparam int CW    = 8;
   localparam int TW    = 32;
   localparam int DEPTH = 512;
   localparam int XTW   = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          in_wr;
   logic          in_rdy;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic          out_wr;
   logic          out_rdy;
   logic [TW-1:0] delay_cycles;
   logic          delay_reset;
`ifdef DELAY_STATS_EN
   logic [31:0]   pkt_count;
   logic [31:0]   flush_drop_words;
   logic [31:0]   x_pkt_count;
   logic [31:0]   x_flush_drop_words;
`endif

   pkt_delay_line u_dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_ctrl      (in_ctrl),
      .in_wr        (in_wr),
      .in_rdy       (in_rdy),
      .out_data     (out_data),
      .out_ctrl     (out_ctrl),
      .out_wr       (out_wr),
      .out_rdy      (out_rdy),
      .delay_cycles (delay_cycles),
      .delay_reset  (delay_reset)
`ifdef DELAY_STATS_EN
      ,
      .pkt_count        (pkt_count),
      .flush_drop_words (flush_drop_words)
`endif
   );

   // ---------------- wrap DUT (8-bit timestamp) ----------------
   logic [DW-1:0]  x_in_data;
   logic [CW-1:0]  x_in_ctrl;
   logic           x_in_wr;
   logic           x_in_rdy;
   logic [DW-1:0]  x_out_data;
   logic [CW-1:0]  x_out_ctrl;
   logic           x_out_wr;
   logic           x_out_rdy;
   logic [XTW-1:0] x_delay_cycles;
   logic           x_delay_reset;

   pkt_delay_line #(
      .DATA_WIDTH      (DW),
      .FIFO_DEPTH_BITS (4),
      .TS_WIDTH        (XTW)
   ) u_wrap (
      .clk          (clk),
      .reset        (reset),
      .in_data      (x_in_data),
      .in_ctrl      (x_in_ctrl),
      .in_wr        (x_in_wr),
      .in_rdy       (x_in_rdy),
      .out_data     (x_out_data),
      .out_ctrl     (x_out_ctrl),
      .out_wr       (x_out_wr),
      .out_rdy      (x_out_rdy),
      .delay_cycles (x_delay_cycles),
      .delay_reset  (x_delay_reset)
`ifdef DELAY_STATS_EN
      ,
      .pkt_count        (x_pkt_count),
      .flush_drop_words (x_flush_drop_words)
`endif
   );

   // ---------------- scoreboard bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
      logic [TW-1:0] ts;
   } entry_t;

   entry_t        m_q[$];
   logic [TW-1:0] m_now;
   logic          m_out_wr;
   logic [DW-1:0] m_out_data;
   logic [CW-1:0] m_out_ctrl;
   longint        m_pkt;
   longint        m_flush;

   always @(posedge clk) begin
      bit            full;
      logic [TW-1:0] age;
      entry_t        e;
      if (reset) begin
         m_q.delete();
         m_now      = '0;
         m_out_wr   = 1'b0;
         m_out_data = '0;
         m_out_ctrl = '0;
         m_pkt      = 0;
         m_flush    = 0;
      end else begin
         full = (m_q.size() == DEPTH);
         m_out_wr = 1'b0;
         if (delay_reset) begin
            m_flush = m_flush + m_q.size() + (in_wr ? 1 : 0);
            if (m_flush > 64'h0000_0000_FFFF_FFFF) m_flush = 64'h0000_0000_FFFF_FFFF;
            m_q.delete();
         end else begin
            if (m_q.size() > 0 && out_rdy) begin
               age = m_now - m_q[0].ts;
               if (age >= delay_cycles) begin
                  e          = m_q.pop_front();
                  m_out_wr   = 1'b1;
                  m_out_data = e.data;
                  m_out_ctrl = e.ctrl;
                  if (e.ctrl == 8'hFF && m_pkt < 64'h0000_0000_FFFF_FFFF) m_pkt++;
               end
            end
            if (in_wr && !full) m_q.push_back('{in_ctrl, in_data, m_now});
         end
         m_now = m_now + 32'd1;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_wr",   64'(out_wr),   64'(m_out_wr));
         check("out_data", out_data,      m_out_data);
         check("out_ctrl", 64'(out_ctrl), 64'(m_out_ctrl));
         check("in_rdy",   64'(in_rdy),   64'(m_q.size() < DEPTH - 1));
`ifdef DELAY_STATS_EN
         check("pkt_count",        64'(pkt_count),        64'(m_pkt));
         check("flush_drop_words", 64'(flush_drop_words), 64'(m_flush));
`endif
      end
   end

   // ---------------- output logs for sequence checks ----------------
   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
   } obs_t;

   obs_t out_log[$];
   obs_t x_log[$];

   always @(negedge clk) begin
      if (out_wr === 1'b1) out_log.push_back('{cyc, out_data, out_ctrl});
      if (x_out_wr === 1'b1) x_log.push_back('{cyc, x_out_data, x_out_ctrl});
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
      in_data = d;
      in_ctrl = c;
      in_wr   = 1'b1;
      step();
      in_wr   = 1'b0;
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [TW-1:0] dly;
      logic [DW-1:0] data;
      logic [CW-1:0] ctrl;
      int            exp_lat;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int t;
      int n;
      int r;
      logic [CW-1:0] pkt_ctrl [3];

      vecs[0] = '{32'd0,   64'h0123_4567_89AB_CDEF, 8'hFF, 2};
      vecs[1] = '{32'd1,   64'hDEAD_BEEF_0000_0001, 8'h00, 2};
      vecs[2] = '{32'd2,   64'hCAFE_F00D_1234_5678, 8'h10, 3};
      vecs[3] = '{32'd10,  64'h1111_2222_3333_4444, 8'hFF, 11};
      vecs[4] = '{32'd37,  64'h5555_6666_7777_8888, 8'h0F, 38};
      vecs[5] = '{32'd100, 64'h9999_AAAA_BBBB_CCCC, 8'h80, 101};
      pkt_ctrl[0] = 8'hFF;
      pkt_ctrl[1] = 8'h00;
      pkt_ctrl[2] = 8'h10;

      reset          = 1'b1;
      in_data        = '0;
      in_ctrl        = '0;
      in_wr          = 1'b0;
      out_rdy        = 1'b1;
      delay_cycles   = '0;
      delay_reset    = 1'b0;
      x_in_data      = '0;
      x_in_ctrl      = '0;
      x_in_wr        = 1'b0;
      x_out_rdy      = 1'b1;
      x_delay_cycles = 8'd16;
      x_delay_reset  = 1'b0;

      step();
      chk_en = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();

      // reset state
      check("rst_out_wr",   64'(out_wr),   64'd0);
      check("rst_out_data", out_data,      64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_in_rdy",   64'(in_rdy),   64'd1);
      check("rst_x_in_rdy", 64'(x_in_rdy), 64'd1);
`ifdef DELAY_STATS_EN
      check("rst_pkt_count", 64'(pkt_count),        64'd0);
      check("rst_flush",     64'(flush_drop_words), 64'd0);
`endif

      // single-word latency table
      for (int i = 0; i < 6; i++) begin
         delay_cycles = vecs[i].dly;
         step();
         out_log.delete();
         t = cyc;
         write_word(vecs[i].data, vecs[i].ctrl);
         repeat (vecs[i].exp_lat + 20) step();
         check("vec_count", 64'(out_log.size()), 64'd1);
         if (out_log.size() > 0) begin
            check("vec_latency", 64'(out_log[0].cyc - t), 64'(vecs[i].exp_lat));
            check("vec_data",    out_log[0].data,         vecs[i].data);
            check("vec_ctrl",    64'(out_log[0].ctrl),    64'(vecs[i].ctrl));
         end
      end

      // zero delay, 3-word packet back to back
      delay_cycles = 32'd0;
      step();
      out_log.delete();
      t = cyc;
      for (int i = 0; i < 3; i++) write_word(64'hB000_0000_0000_0000 + 64'(i), pkt_ctrl[i]);
      repeat (10) step();
      check("pkt3_count", 64'(out_log.size()), 64'd3);
      for (int i = 0; i < 3 && i < out_log.size(); i++) begin
         check("pkt3_cycle", 64'(out_log[i].cyc - t), 64'(2 + i));
         check("pkt3_data",  out_log[i].data,         64'hB000_0000_0000_0000 + 64'(i));
         check("pkt3_ctrl",  64'(out_log[i].ctrl),    64'(pkt_ctrl[i]));
      end

      // fill to the in_rdy threshold, one late write, one dropped write
      delay_cycles = 32'd1000;
      step();
      out_log.delete();
      t = cyc;
      for (int i = 0; i < 511; i++) begin
         if (i == 510) check("fill_rdy_before", 64'(in_rdy), 64'd1);
         write_word({32'h3000_0000, 32'(i)}, (i == 0) ? 8'hFF : 8'h00);
      end
      check("fill_rdy_after", 64'(in_rdy), 64'd0);
      write_word({32'h3000_0000, 32'd511}, 8'h00);
      write_word({32'hDDDD_DDDD, 32'd512}, 8'h00);
      check("fill_rdy_full", 64'(in_rdy), 64'd0);
      repeat (1100) step();
      check("fill_count", 64'(out_log.size()), 64'd512);
      if (out_log.size() > 0) check("fill_latency", 64'(out_log[0].cyc - t), 64'd1001);
      for (int i = 0; i < out_log.size(); i++) begin
         if (out_log[i].data !== {32'h3000_0000, 32'(i)} || out_log[i].cyc != out_log[0].cyc + i)
            check("fill_order", out_log[i].data, {32'h3000_0000, 32'(i)});
      end
      check("fill_rdy_drained", 64'(in_rdy), 64'd1);

      // flush with a simultaneous write
      out_log.delete();
      for (int i = 0; i < 20; i++) write_word(64'h4000_0000_0000_0000 + 64'(i), 8'h00);
      in_data     = 64'h4FFF_FFFF_FFFF_FFFF;
      in_wr       = 1'b1;
      delay_reset = 1'b1;
      step();
      in_wr       = 1'b0;
      delay_reset = 1'b0;
      check("flush_rdy", 64'(in_rdy), 64'd1);
      check("flush_out_wr", 64'(out_wr), 64'd0);
`ifdef DELAY_STATS_EN
      check("flush_drop_21", 64'(flush_drop_words), 64'd21);
`endif
      repeat (1100) step();
      check("flush_no_output", 64'(out_log.size()), 64'd0);

      // downstream stall then release
      delay_cycles = 32'd5;
      out_rdy      = 1'b0;
      out_log.delete();
      for (int i = 0; i < 4; i++) write_word(64'h5000_0000_0000_0000 + 64'(i), 8'h00);
      repeat (30) step();
      check("stall_none", 64'(out_log.size()), 64'd0);
      n = cyc;
      out_rdy = 1'b1;
      repeat (10) step();
      check("stall_count", 64'(out_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < out_log.size(); i++) begin
         check("stall_cycle", 64'(out_log[i].cyc - n), 64'(1 + i));
         check("stall_data",  out_log[i].data,         64'h5000_0000_0000_0000 + 64'(i));
      end

      // timestamp wrap on the 8-bit instance: write when now = 0xF8
      for (int k = 0; k < 300 && m_now[7:0] != 8'hF8; k++) step();
      x_log.delete();
      x_in_data = 64'h6000_0000_0000_00F8;
      x_in_ctrl = 8'hFF;
      x_in_wr   = 1'b1;
      t = cyc;
      step();
      x_in_wr = 1'b0;
      repeat (30) step();
      check("wrap_count", 64'(x_log.size()), 64'd1);
      if (x_log.size() > 0) begin
         check("wrap_latency", 64'(x_log[0].cyc - t), 64'd17);
         check("wrap_data",    x_log[0].data,         64'h6000_0000_0000_00F8);
      end

      // randomized traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if (k % 60 == 0) delay_cycles = 32'($urandom_range(0, 20));
         out_rdy     = ($urandom_range(0, 3) != 0);
         delay_reset = ($urandom_range(0, 299) == 0);
         in_wr       = (m_q.size() < DEPTH - 1) && ($urandom_range(0, 2) != 0);
         in_data     = {$urandom, $urandom};
         r           = $urandom_range(0, 3);
         in_ctrl     = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
         step();
      end
      in_wr       = 1'b0;
      delay_reset = 1'b0;
      out_rdy     = 1'b1;
      repeat (40) step();

      // reset wins over a simultaneous delay_reset
      delay_cycles = 32'd1000;
      for (int i = 0; i < 5; i++) write_word(64'h7000_0000_0000_0000 + 64'(i), 8'hFF);
      reset       = 1'b1;
      delay_reset = 1'b1;
      step();
      reset       = 1'b0;
      delay_reset = 1'b0;
      step();
      check("rst2_out_wr",   64'(out_wr), 64'd0);
      check("rst2_out_data", out_data,    64'd0);
      check("rst2_in_rdy",   64'(in_rdy), 64'd1);
`ifdef DELAY_STATS_EN
      check("rst2_flush", 64'(flush_drop_words), 64'd0);
      check("rst2_pkt",   64'(pkt_count),        64'd0);
`endif
      delay_cycles = 32'd0;
      out_log.delete();
      write_word(64'h8888_0000_0000_0001, 8'h00);
      repeat (10) step();
      check("rst2_count", 64'(out_log.size()), 64'd1);
      if (out_log.size() > 0) check("rst2_data", out_log[0].data, 64'h8888_0000_0000_0001);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
